bcd_seven_seg_scanner: RTL and testbench



---
 rtl/bcd_seven_seg_scanner.sv | 203 ++++++++++++++++++++
 tb/tb_bcd_seven_seg_scanner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/bcd_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// bcd_seven_seg_scanner
//
// Purpose:
//   Captures a packed BCD word from the upstream binary-to-BCD converter on
//   each data-valid strobe. It time-multiplexes the captured digits onto a
//   common-anode seven-segment display. Digits are shown one at a time. An
//   all-off blanking interval separates consecutive digits so that segment
//   data for one digit never ghosts onto the next.
//
// Ports:
//   i_Clock     in   1                 system clock, rising edge
//   i_Reset     in   1                 synchronous active-high reset
//   i_BCD       in   DECIMAL_DIGITS*4  packed BCD, digit 0 in [3:0]
//   i_DV        in   1                 single-cycle strobe, i_BCD valid when high
//   o_Segments  out  7                 active-low segments, gfedcba (bit0 = a)
//   o_Anodes    out  DECIMAL_DIGITS    active-low one-hot digit enable
//
// Parameters:
//   DECIMAL_DIGITS  number of BCD digits and number of anodes driven
//   REFRESH_COUNT   cycles each digit is driven (>= 1)
//   BLANK_CYCLES    cycles all anodes are off between digits (>= 1)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          non-zero digit are shown as all segments off.
//                          Their anodes are still driven and the scan timing
//                          does not change. Digit 0 is never blanked.
// ---------------------------------------------------------------------------
module bcd_seven_seg_scanner #(
  parameter int DECIMAL_DIGITS = 2,
  parameter int REFRESH_COUNT  = 50000,
  parameter int BLANK_CYCLES   = 500
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic [DECIMAL_DIGITS*4-1:0]   i_BCD,
  input  logic                          i_DV,
  output logic [6:0]                    o_Segments,
  output logic [DECIMAL_DIGITS-1:0]     o_Anodes
);

  // The counter must reach the longer of the two dwell times.
  localparam int CNT_MAX = (REFRESH_COUNT > BLANK_CYCLES) ? REFRESH_COUNT : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (DECIMAL_DIGITS > 1) ? $clog2(DECIMAL_DIGITS) : 1;

  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST   = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DECIMAL_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF      = 7'h7F;

  typedef enum logic {
    s_BLANK = 1'b0,
    s_DRIVE = 1'b1
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t                        state_q,   state_d;
  logic [CNT_W-1:0]              cnt_q,     cnt_d;
  logic [IDX_W-1:0]              idx_q,     idx_d;
  logic [DECIMAL_DIGITS*4-1:0]   display_q, display_d;
  logic [6:0]                    seg_q,     seg_d;
  logic [DECIMAL_DIGITS-1:0]     anode_q,   anode_d;

  // Captured word split into one nibble per digit.
  logic [3:0] digit_arr [DECIMAL_DIGITS];
  logic [3:0] cur_digit;

  generate
    for (genvar gi = 0; gi < DECIMAL_DIGITS; gi++) begin : g_digit_split
      assign digit_arr[gi] = display_q[gi*4 +: 4];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Segment decode, active low, gfedcba. Nibbles A-F show a dash.
  // -------------------------------------------------------------------------
  function automatic logic [6:0] decode_digit(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h3F;
    endcase
    return seg;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic: capture, dwell counter, digit index
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;

    // Capture does not depend on scan state, so a strobe is never lost.
    display_d = i_DV ? i_BCD : display_q;

    case (state_q)
      s_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = s_DRIVE;
          cnt_d   = '0;
        end
      end
      s_DRIVE: begin
        if (cnt_q == REFRESH_LAST) begin
          state_d = s_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
      end
      default: begin
        state_d = s_BLANK;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic. Outputs are computed from the next state and next index,
  // so anodes and segments change on the same edge as the state. Segment data
  // comes from the registered display word. A new capture therefore appears
  // one edge after it is sampled, and no path exists from the inputs to the
  // outputs.
  // -------------------------------------------------------------------------
  assign cur_digit = digit_arr[idx_d];

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[n] is high when digit n and every digit above it are zero.
  // Entry 0 is forced low because the units digit is always shown.
  logic [DECIMAL_DIGITS:0] zero_from;
  logic                    blank_digit;

  assign zero_from[DECIMAL_DIGITS] = 1'b1;
  assign zero_from[0]              = 1'b0;

  generate
    for (genvar gi = 1; gi < DECIMAL_DIGITS; gi++) begin : g_lead_zero
      // A-F nibbles are non-zero here, so they stop the blanking chain.
      assign zero_from[gi] = (digit_arr[gi] == 4'd0) && zero_from[gi+1];
    end
  endgenerate

  assign blank_digit = zero_from[idx_d];

  always_comb begin
    seg_d = SEG_OFF;
    if (state_d == s_DRIVE) begin
      seg_d = blank_digit ? SEG_OFF : decode_digit(cur_digit);
    end
  end
`else
  always_comb begin
    seg_d = SEG_OFF;
    if (state_d == s_DRIVE) begin
      seg_d = decode_digit(cur_digit);
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < DECIMAL_DIGITS; gi++) begin : g_anode
      assign anode_d[gi] = !((state_d == s_DRIVE) && (idx_d == IDX_W'(gi)));
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Registers. Reset overrides a simultaneous capture strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= s_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      display_q <= '0;
      seg_q     <= SEG_OFF;
      anode_q   <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      display_q <= display_d;
      seg_q     <= seg_d;
      anode_q   <= anode_d;
    end
  end

  assign o_Segments = seg_q;
  assign o_Anodes   = anode_q;

endmodule

// File: tb/tb_bcd_seven_seg_scanner.sv
// ---------------------------------------------------------------------------
// tb_bcd_seven_seg_scanner
//
// Purpose:
//   Directed testbench for bcd_seven_seg_scanner. It uses DECIMAL_DIGITS=2,
//   REFRESH_COUNT=4 and BLANK_CYCLES=2, so one frame is 12 cycles. Inputs
//   are driven and outputs are sampled 1 time unit after each rising edge.
//
// Ports:
//   none (top-level testbench)
//
// Build option:
//   LEADING_ZERO_BLANK_EN  selects the expected segment pattern for a zero
//                          leading digit.
// ---------------------------------------------------------------------------
module tb_bcd_seven_seg_scanner;

  localparam int DIGITS  = 2;
  localparam int REFRESH = 4;
  localparam int BLANK   = 2;

  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [1:0] AN_D0  = 2'b10;
  localparam logic [1:0] AN_D1  = 2'b01;
  localparam logic [6:0] SEG_OFF = 7'h7F;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LEAD_ZERO = 7'h7F;
`else
  localparam logic [6:0] LEAD_ZERO = 7'h40;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [7:0]      bcd;
  logic            dv;
  logic [6:0]      seg;
  logic [1:0]      an;

  int pass_cnt  = 0;
  int total_cnt = 0;

  bcd_seven_seg_scanner #(
    .DECIMAL_DIGITS (DIGITS),
    .REFRESH_COUNT  (REFRESH),
    .BLANK_CYCLES   (BLANK)
  ) dut (
    .i_Clock    (clk),
    .i_Reset    (rst),
    .i_BCD      (bcd),
    .i_DV       (dv),
    .o_Segments (seg),
    .o_Anodes   (an)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [1:0] an_exp, input logic [6:0] seg_exp);
    total_cnt++;
    assert (an === an_exp && seg === seg_exp) begin
      pass_cnt++;
      $display("t=%0t %s: anodes=%b seg=%h ok", $time, tag, an, seg);
    end else begin
      $error("FAIL %s: anodes=%b seg=%h, expected anodes=%b seg=%h",
             tag, an, seg, an_exp, seg_exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    dv  = 1'b0;
    bcd = 8'h00;

    // 1. Reset held for three cycles, then one full frame of scan timing.
    repeat (3) tick();
    check("reset", AN_OFF, SEG_OFF);
    rst = 1'b0;
    tick(); check("post_rst_blank2", AN_OFF, SEG_OFF);
    for (int i = 0; i < REFRESH; i++) begin
      tick(); check("frame_d0", AN_D0, 7'h40);
    end
    for (int i = 0; i < BLANK; i++) begin
      tick(); check("frame_blank_a", AN_OFF, SEG_OFF);
    end
    for (int i = 0; i < REFRESH; i++) begin
      tick(); check("frame_d1", AN_D1, 7'h40);
    end
    for (int i = 0; i < BLANK; i++) begin
      tick(); check("frame_blank_b", AN_OFF, SEG_OFF);
    end
    tick(); check("period12_d0", AN_D0, 7'h40);

    // 3. Mid-drive update: strobe 8'h07 during the 2nd cycle of digit 0 drive.
    tick(); check("mid_cycle2", AN_D0, 7'h40);
    bcd = 8'h07; dv = 1'b1;
    tick(); dv = 1'b0; bcd = 8'h99;  // i_BCD changes without a strobe must be ignored
    check("mid_capture_edge", AN_D0, 7'h40);
    tick(); check("mid_updated", AN_D0, 7'h78);
    tick(); check("mid_blank1", AN_OFF, SEG_OFF);
    tick(); check("mid_blank2", AN_OFF, SEG_OFF);
    // Captured word is 8'h07, so digit 1 is a leading zero.
    tick(); check("lz07_d1", AN_D1, LEAD_ZERO);

    // 2. Capture and decode 8'h42; later i_BCD noise without a strobe must not show.
    bcd = 8'h42; dv = 1'b1;
    tick(); dv = 1'b0; bcd = 8'h99;
    check("cap42_edge", AN_D1, LEAD_ZERO);
    tick(); check("cap42_d1", AN_D1, 7'h19);
    tick(); check("cap42_d1_hold", AN_D1, 7'h19);
    tick(); check("cap42_blank1", AN_OFF, SEG_OFF);
    tick(); check("cap42_blank2", AN_OFF, SEG_OFF);
    tick(); check("cap42_d0", AN_D0, 7'h24);

    // 5. Invalid nibble 8'hB3.
    bcd = 8'hB3; dv = 1'b1;
    tick(); dv = 1'b0;
    check("b3_edge", AN_D0, 7'h24);
    tick(); check("b3_d0", AN_D0, 7'h30);
    tick(); check("b3_d0_hold", AN_D0, 7'h30);
    tick(); tick();
    tick(); check("b3_d1_dash", AN_D1, 7'h3F);

    // 4. Leading zeros: 8'h05 then 8'h00.
    bcd = 8'h05; dv = 1'b1;
    tick(); dv = 1'b0;
    check("lz05_edge", AN_D1, 7'h3F);
    tick(); check("lz05_d1", AN_D1, LEAD_ZERO);
    tick(); check("lz05_d1_hold", AN_D1, LEAD_ZERO);
    tick(); tick();
    tick(); check("lz05_d0", AN_D0, 7'h12);
    bcd = 8'h00; dv = 1'b1;
    tick(); dv = 1'b0;
    check("lz00_edge", AN_D0, 7'h12);
    tick(); check("lz00_d0_shows0", AN_D0, 7'h40);
    tick(); tick(); tick();
    tick(); check("lz00_d1", AN_D1, LEAD_ZERO);

    // Back-to-back strobes keep the last value.
    bcd = 8'h11; dv = 1'b1;
    tick(); bcd = 8'h88;
    tick(); dv = 1'b0; bcd = 8'h00;
    tick(); check("b2b_d1_last", AN_D1, 7'h00);

    // 6. Reset together with a strobe in the middle of digit 1 drive.
    rst = 1'b1; dv = 1'b1; bcd = 8'h55;
    tick(); check("rst_prio", AN_OFF, SEG_OFF);
    rst = 1'b0; dv = 1'b0; bcd = 8'h00;
    tick(); check("rst_blank2", AN_OFF, SEG_OFF);
    // Display must be cleared to 0, so digit 0 shows "0" and not 8 or 5.
    tick(); check("rst_restart_d0", AN_D0, 7'h40);
    tick(); tick(); tick();
    tick(); tick();
    tick(); check("rst_d1_zero", AN_D1, LEAD_ZERO);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
